// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table, all-off levels, scan states.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic       DP_OFF  = 1'b1;

  // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {StGuard, StShow} scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nib_i];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with double-buffered digit data and
// an all-off guard window at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 2000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_done_o
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW   = 4 * NUM_DIGITS;

  localparam logic [CntW-1:0]       CntLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]       CntBlank = CntW'(BLANK_CYC);
  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AnOff    = '1;
  localparam logic [NUM_DIGITS-1:0] AnOne    = NUM_DIGITS'(1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  scan_state_e           state_q, state_d;
  logic [DW-1:0]         pend_data_q, shd_data_q;
  logic [NUM_DIGITS-1:0] pend_dp_q, shd_dp_q;
  logic [NUM_DIGITS-1:0] pend_blank_q, shd_blank_q;
  logic                  pend_valid_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q;

  logic       slot_end, frame_end;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;

  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (idx_q == IdxLast);
  assign cur_nib   = shd_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    // With no guard window the reset-time GUARD state must clear on the first edge.
    if (BLANK_CYC == 0) begin
      state_d = StShow;
    end else if (cnt_d == '0) begin
      state_d = StGuard;
    end else if (cnt_d == CntBlank) begin
      state_d = StShow;
    end else begin
      state_d = state_q;
    end

    an_d  = AnOff;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (state_q == StShow && !shd_blank_q[idx_q]) begin
      an_d  = ~(AnOne << idx_q);
      seg_d = cur_seg;
      dp_d  = ~shd_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= StGuard;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      an_q         <= AnOff;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      fd_q         <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= frame_end;

      // Shadow only changes on the frame boundary; a load on that very cycle bypasses pending.
      if (load_i && frame_end) begin
        shd_data_q   <= data_i;
        shd_dp_q     <= dp_in_i;
        shd_blank_q  <= blank_i;
        pend_valid_q <= 1'b0;
      end else if (load_i) begin
        pend_data_q  <= data_i;
        pend_dp_q    <= dp_in_i;
        pend_blank_q <= blank_i;
        pend_valid_q <= 1'b1;
      end else if (frame_end && pend_valid_q) begin
        shd_data_q   <= pend_data_q;
        shd_dp_q     <= pend_dp_q;
        shd_blank_q  <= pend_blank_q;
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-level reference model predicts every output cycle of two
// driver instances (guard of 2 cycles and no guard) under random and directed loads.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data), .dp_in_i(dp_in), .blank_i(blank),
    .load_i(load), .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a), .frame_done_o(fd_a)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYC(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data), .dp_in_i(dp_in), .blank_i(blank),
    .load_i(load), .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b), .frame_done_o(fd_b)
  );

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: what the current frame shows, and the last load seen during it.
  logic [15:0] cur_data, nxt_data;
  logic [3:0]  cur_dp, nxt_dp, cur_blank, nxt_blank;
  logic        nxt_valid;
  int          c;

  out_t qa[$];
  out_t qb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   fd_seen = 0;
  int   fd_exp = 0;

  function automatic out_t model(input int cyc, input int blankc);
    out_t o;
    int   pos, d;
    pos   = cyc % DIV;
    d     = (cyc / DIV) % N;
    o.fd  = (cyc % FRAME) == FRAME - 1;
    o.an  = 4'hF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    // Cycle 0 after reset is always dark: the scan starts from the guard state.
    if (pos >= blankc && cyc != 0 && !cur_blank[d]) begin
      o.an  = ~(4'b0001 << d);
      o.seg = seg_ref[cur_data[4*d +: 4]];
      o.dp  = ~cur_dp[d];
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", name, c, got, exp);
  endtask

  task automatic model_reset();
    c         = 0;
    cur_data  = '0;
    cur_dp    = '0;
    cur_blank = '0;
    nxt_data  = '0;
    nxt_dp    = '0;
    nxt_blank = '0;
    nxt_valid = 1'b0;
  endtask

  // Called at a falling edge: drives cycle c and predicts its outputs.
  task automatic step(input logic ld, input logic [15:0] dt, input logic [3:0] dpv,
                      input logic [3:0] bk);
    if (c > 0 && (c % FRAME) == 0 && nxt_valid) begin
      cur_data  = nxt_data;
      cur_dp    = nxt_dp;
      cur_blank = nxt_blank;
      nxt_valid = 1'b0;
    end
    load  = ld;
    data  = dt;
    dp_in = dpv;
    blank = bk;
    qa.push_back(model(c, BLK));
    qb.push_back(model(c, 0));
    if (ld) begin
      nxt_data  = dt;
      nxt_dp    = dpv;
      nxt_blank = bk;
      nxt_valid = 1'b1;
    end
    c++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic align(input int phase);
    while ((c % FRAME) != phase) idle();
  endtask

  initial begin : monitor
    out_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("guarded_out", 32'({an_a, seg_a, dp_a, fd_a}), 32'(ea));
        chk("noguard_out", 32'({an_b, seg_b, dp_b, fd_b}), 32'(eb));
        fd_seen += int'(fd_a);
        fd_exp  += int'(ea.fd);
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_an", 32'(an_a), 32'h0000_000F);
    chk("reset_seg_dp_fd", 32'({seg_a, dp_a, fd_a}), 32'({7'h7F, 1'b1, 1'b0}));
    @(negedge clk);
    rst = 1'b0;

    // First frame shows zeros while the load waits for the boundary.
    step(1'b1, 16'h3210, 4'h0, 4'h0);
    idle_n(2 * FRAME + 13);

    // Asynchronous reset mid-slot darkens immediately.
    #2 rst = 1'b1;
    #1;
    chk("midrst_a", 32'({an_a, seg_a, dp_a}), 32'({4'hF, 7'h7F, 1'b1}));
    chk("midrst_b", 32'({an_b, seg_b, dp_b, fd_b}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Last load in a frame wins.
    idle_n(3);
    align(0);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    idle_n(7);
    step(1'b1, 16'hFFFF, 4'h0, 4'h0);
    idle_n(2 * FRAME);

    // Blanked digit 2, decimal point on digit 0.
    align(5);
    step(1'b1, 16'($urandom), 4'b0001, 4'b0100);
    idle_n(2 * FRAME);

    // Load on the boundary cycle goes straight to the next frame.
    align(FRAME - 1);
    step(1'b1, 16'hA5C7, 4'b1010, 4'h0);
    idle_n(FRAME + 8);

    // Random traffic.
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else idle();
    end

    repeat (3) @(negedge clk);
    chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
